// File: rtl/uart_pkg.sv
// Shared register map, status bit positions and FSM state type for the
// Avalon-MM UART responder.
package uart_pkg;

  localparam logic [4:0] RX_BASE     = 5'd0;
  localparam logic [4:0] TX_BASE     = 5'd4;
  localparam logic [4:0] STATUS_BASE = 5'd8;

  localparam int unsigned TX_OK_BIT = 6;
  localparam int unsigned RX_OK_BIT = 7;
  localparam int unsigned OVR_BIT   = 0;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: input synchronizer, RX FSM, byte output with a
// one-cycle valid pulse. Framing errors and start-bit glitches are dropped.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       valid_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  uart_state_t     state_q, state_d;
  logic [1:0]      sync_q;
  logic            rx_s;
  logic            prev_q;
  logic [CntW-1:0] baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      shreg_q;
  logic [7:0]      byte_q;
  logic            valid_q;
  logic            half_tick, bit_tick;
  logic            shift_en, frame_end;

  assign rx_s      = sync_q[1];
  assign half_tick = (baud_q == HalfLast);
  assign bit_tick  = (baud_q == BitLast);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (prev_q && !rx_s) state_d = StStart;
      // A line that is high again at mid-start-bit was only a glitch.
      StStart: if (half_tick) state_d = rx_s ? StIdle : StData;
      StData:  if (bit_tick && bit_q == 3'd7) state_d = StStop;
      StStop:  if (bit_tick) state_d = StIdle;
    endcase
  end

  always_comb begin
    shift_en  = (state_q == StData) && bit_tick;
    frame_end = (state_q == StStop) && bit_tick;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      prev_q  <= rx_s;
      valid_q <= 1'b0;
      if (state_q == StIdle || (state_q == StStart && half_tick) || bit_tick) begin
        baud_q <= '0;
      end else begin
        baud_q <= baud_q + CntW'(1);
      end
      if (state_q == StIdle) begin
        bit_q <= '0;
      end
      if (shift_en) begin
        shreg_q <= {rx_s, shreg_q[7:1]};
        bit_q   <= bit_q + 3'd1;
      end
      if (frame_end && rx_s) begin
        byte_q  <= shreg_q;
        valid_q <= 1'b1;
      end
    end
  end

  assign byte_o  = byte_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/avm_uart_responder.sv
// Avalon-MM RX/TX/STATUS responder driving an 8N1 UART pin pair.
// Define AVM_UART_RX_FIFO_EN to replace the RX holding register with an 8-entry FIFO.
module avm_uart_responder
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  input  logic [4:0]  avm_address,
  input  logic        avm_read,
  output logic [31:0] avm_readdata,
  input  logic        avm_write,
  input  logic [31:0] avm_writedata,
  output logic        avm_waitrequest,
  input  logic        i_uart_rx,
  output logic        o_uart_tx
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast = CntW'(CLKS_PER_BIT - 1);

  logic       ack_q;
  logic       rd_ack, wr_ack, rx_rd, st_rd, tx_start;
  logic [7:0] rx_byte;
  logic       rx_done;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       ovr_set;
  logic       overrun_q;
  logic       tx_busy;
  logic       unused_wdata;

  assign unused_wdata = ^avm_writedata[31:8];

  // Fixed single wait cycle: ack goes high the cycle after a request is seen.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= (avm_read | avm_write) & ~ack_q;
    end
  end

  assign avm_waitrequest = ~ack_q;
  assign rd_ack   = ack_q & avm_read;
  assign wr_ack   = ack_q & avm_write & ~avm_read;
  assign rx_rd    = rd_ack && (avm_address == RX_BASE);
  assign st_rd    = rd_ack && (avm_address == STATUS_BASE);
  assign tx_start = wr_ack && (avm_address == TX_BASE) && !tx_busy;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i  (avm_clk),
    .rst_i  (avm_rst),
    .rx_i   (i_uart_rx),
    .byte_o (rx_byte),
    .valid_o(rx_done)
  );

`ifdef AVM_UART_RX_FIFO_EN
  logic [7:0] fifo_q [8];
  logic [2:0] wptr_q, rptr_q;
  logic [3:0] count_q;
  logic       full, empty, push, pop;

  assign full  = (count_q == 4'd8);
  assign empty = (count_q == 4'd0);
  assign pop   = rx_rd && !empty;
  assign push  = rx_done && (!full || pop);

  always_ff @(posedge avm_clk) begin
    if (push) begin
      fifo_q[wptr_q] <= rx_byte;
    end
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 3'd1;
      if (pop)  rptr_q <= rptr_q + 3'd1;
      count_q <= count_q + 4'(push) - 4'(pop);
    end
  end

  assign rx_valid = !empty;
  assign rx_data  = empty ? 8'h00 : fifo_q[rptr_q];
  assign ovr_set  = rx_done && full && !pop;
`else
  logic [7:0] rx_byte_q;
  logic       rx_valid_q;

  // A byte landing in the same cycle as an RX read is kept, not flagged.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
    end else if (rx_done) begin
      rx_byte_q  <= rx_byte;
      rx_valid_q <= 1'b1;
    end else if (rx_rd) begin
      rx_valid_q <= 1'b0;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_byte_q;
  assign ovr_set  = rx_done && rx_valid_q && !rx_rd;
`endif

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      overrun_q <= 1'b0;
    end else if (ovr_set) begin
      overrun_q <= 1'b1;
    end else if (st_rd) begin
      overrun_q <= 1'b0;
    end
  end

  always_comb begin
    avm_readdata = '0;
    if (rd_ack) begin
      case (avm_address)
        RX_BASE: avm_readdata[7:0] = rx_data;
        STATUS_BASE: begin
          avm_readdata[TX_OK_BIT] = !tx_busy;
          avm_readdata[RX_OK_BIT] = rx_valid;
          avm_readdata[OVR_BIT]   = overrun_q;
        end
        default: avm_readdata = '0;
      endcase
    end
  end

  // TX FSM
  uart_state_t     tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_baud_q;
  logic [2:0]      tx_bit_q;
  logic [7:0]      tx_shreg_q;
  logic            tx_bit_tick;

  assign tx_bit_tick = (tx_baud_q == BitLast);

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      tx_state_q <= StIdle;
    end else begin
      tx_state_q <= tx_state_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      StIdle:  if (tx_start) tx_state_d = StStart;
      StStart: if (tx_bit_tick) tx_state_d = StData;
      StData:  if (tx_bit_tick && tx_bit_q == 3'd7) tx_state_d = StStop;
      StStop:  if (tx_bit_tick) tx_state_d = StIdle;
    endcase
  end

  always_comb begin
    o_uart_tx = 1'b1;
    tx_busy   = 1'b1;
    unique case (tx_state_q)
      StIdle:  tx_busy = 1'b0;
      StStart: o_uart_tx = 1'b0;
      StData:  o_uart_tx = tx_shreg_q[0];
      StStop:  o_uart_tx = 1'b1;
    endcase
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shreg_q <= '0;
    end else if (tx_state_q == StIdle) begin
      tx_baud_q <= '0;
      tx_bit_q  <= '0;
      if (tx_start) begin
        tx_shreg_q <= avm_writedata[7:0];
      end
    end else begin
      tx_baud_q <= tx_bit_tick ? '0 : tx_baud_q + CntW'(1);
      if (tx_state_q == StData && tx_bit_tick) begin
        tx_shreg_q <= {1'b0, tx_shreg_q[7:1]};
        tx_bit_q   <= tx_bit_q + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_avm_uart_responder.sv
// Self-checking bench for avm_uart_responder at 10 clocks per bit.
// Build with AVM_UART_RX_FIFO_EN defined to check the FIFO variant.
module tb_avm_uart_responder;

  localparam int K_RD = 0;
  localparam int K_WR = 1;
  localparam int K_RX = 2;
  localparam int K_RW = 3;

  typedef struct {
    int          kind;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [4:0]  address;
  logic        read;
  logic [31:0] readdata;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;
  logic        uart_rx;
  logic        uart_tx;

  int n_checks = 0;
  int n_err    = 0;
  vec_t vecs[$];

  avm_uart_responder #(
    .CLK_FREQ(1_000_000),
    .BAUD    (100_000)
  ) dut (
    .avm_clk        (clk),
    .avm_rst        (rst),
    .avm_address    (address),
    .avm_read       (read),
    .avm_readdata   (readdata),
    .avm_write      (write),
    .avm_writedata  (writedata),
    .avm_waitrequest(waitrequest),
    .i_uart_rx      (uart_rx),
    .o_uart_tx      (uart_tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_xfer(input logic rd, input logic wr, input logic [4:0] a,
                          input logic [31:0] wd, output logic [31:0] rdat, output int waits);
    address   = a;
    read      = rd;
    write     = wr;
    writedata = wd;
    waits     = 0;
    while (waitrequest && waits < 20) begin
      waits++;
      step(1);
    end
    rdat = readdata;
    step(1);
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      step(10);
    end
    step(4);
  endtask

  task automatic tx_watch(input logic [7:0] b, input int idle_after);
    logic [9:0] fr;
    int bad;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bad = 0;
      for (int c = 0; c < 10; c++) begin
        if (uart_tx !== fr[i]) bad++;
        step(1);
      end
      check($sformatf("tx_bit%0d_bad_cycles", i), bad, 0);
    end
    bad = 0;
    for (int c = 0; c < idle_after; c++) begin
      if (uart_tx !== 1'b1) bad++;
      step(1);
    end
    check("tx_idle_after_frame_bad_cycles", bad, 0);
  endtask

  task automatic add(input int k, input logic [4:0] a, input logic [31:0] d,
                     input logic [31:0] e, input string n);
    vec_t v;
    v.kind = k; v.addr = a; v.data = d; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] rdat;
    int          waits;
    int          bad;

    rst = 1'b1; address = '0; read = 1'b0; write = 1'b0; writedata = '0; uart_rx = 1'b1;

    add(K_RD, 5'd8,  0, 32'h0000_0040, "status_after_reset");
    add(K_RD, 5'd12, 0, 32'h0000_0000, "reserved_12_read");
    add(K_RD, 5'd28, 0, 32'h0000_0000, "reserved_28_read");
    add(K_RD, 5'd0,  0, 32'h0000_0000, "rx_read_empty");
    add(K_RD, 5'd4,  0, 32'h0000_0000, "tx_addr_read");
    add(K_WR, 5'd8,  32'hFF, 0, "write_status");
    add(K_WR, 5'd0,  32'hFF, 0, "write_rx");
    add(K_WR, 5'd20, 32'hFF, 0, "write_reserved");
    add(K_RD, 5'd8,  0, 32'h0000_0040, "status_after_ignored_writes");
    add(K_RW, 5'd4,  32'hAA, 32'h0000_0000, "read_and_write_tx");
    add(K_RD, 5'd8,  0, 32'h0000_0040, "status_after_rw_no_tx");
    add(K_RX, 5'd0,  32'h5A, 0, "rx_5a");
    add(K_RD, 5'd8,  0, 32'h0000_00C0, "status_rx_ok");
    add(K_RD, 5'd0,  0, 32'h0000_005A, "rx_read_5a");
    add(K_RD, 5'd8,  0, 32'h0000_0040, "status_after_rx_read");
    add(K_RX, 5'd0,  32'h11, 0, "rx_11");
    add(K_RX, 5'd0,  32'h22, 0, "rx_22");
`ifdef AVM_UART_RX_FIFO_EN
    add(K_RD, 5'd8,  0, 32'h0000_00C0, "status_two_bytes_fifo");
    add(K_RD, 5'd0,  0, 32'h0000_0011, "rx_read_11");
    add(K_RD, 5'd8,  0, 32'h0000_00C0, "status_one_left");
    add(K_RD, 5'd0,  0, 32'h0000_0022, "rx_read_22");
`else
    add(K_RD, 5'd8,  0, 32'h0000_00C1, "status_overrun");
    add(K_RD, 5'd0,  0, 32'h0000_0022, "rx_read_22");
`endif
    add(K_RD, 5'd8,  0, 32'h0000_0040, "status_drained");

    step(3);
    check("reset_waitrequest", waitrequest, 1);
    check("reset_readdata", readdata, 0);
    check("reset_tx_line", uart_tx, 1);
    rst = 1'b0;
    step(2);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].kind)
        K_RD: begin
          bus_xfer(1'b1, 1'b0, vecs[i].addr, 0, rdat, waits);
          check(vecs[i].name, rdat, vecs[i].exp);
          check({vecs[i].name, "_waits"}, waits, 1);
          if (i == 0) check("waitrequest_returns_high", waitrequest, 1);
        end
        K_WR: begin
          bus_xfer(1'b0, 1'b1, vecs[i].addr, vecs[i].data, rdat, waits);
          check({vecs[i].name, "_waits"}, waits, 1);
        end
        K_RW: begin
          bus_xfer(1'b1, 1'b1, vecs[i].addr, vecs[i].data, rdat, waits);
          check(vecs[i].name, rdat, vecs[i].exp);
          check({vecs[i].name, "_tx_line"}, uart_tx, 1);
        end
        default: send_rx(vecs[i].data[7:0]);
      endcase
    end

    // TX frame with a dropped mid-frame write and status polling alongside.
    bus_xfer(1'b0, 1'b1, 5'd4, 32'hA5, rdat, waits);
    check("tx_write_waits", waits, 1);
    fork
      tx_watch(8'hA5, 40);
      begin
        step(18);
        bus_xfer(1'b0, 1'b1, 5'd4, 32'h3C, rdat, waits);
        bus_xfer(1'b1, 1'b0, 5'd8, 0, rdat, waits);
        check("status_mid_frame", rdat, 32'h0000_0000);
        step(80);
        bus_xfer(1'b1, 1'b0, 5'd8, 0, rdat, waits);
        check("status_after_frame", rdat, 32'h0000_0040);
      end
    join

    // Reset in the middle of data bit 4 of a 0x00 frame.
    bus_xfer(1'b0, 1'b1, 5'd4, 32'h00, rdat, waits);
    step(55);
    check("tx_bit4_low_before_reset", uart_tx, 0);
    rst = 1'b1;
    #1;
    check("tx_high_async_on_reset", uart_tx, 1);
    step(1);
    rst = 1'b0;
    bus_xfer(1'b1, 1'b0, 5'd8, 0, rdat, waits);
    check("status_after_mid_reset", rdat, 32'h0000_0040);
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      if (uart_tx !== 1'b1) bad++;
      step(1);
    end
    check("tx_aborted_line_high", bad, 0);

    // Three-cycle low glitch must not produce a byte.
    uart_rx = 1'b0;
    step(3);
    uart_rx = 1'b1;
    step(120);
    bus_xfer(1'b1, 1'b0, 5'd8, 0, rdat, waits);
    check("status_after_glitch", rdat, 32'h0000_0040);
    bus_xfer(1'b1, 1'b0, 5'd0, 0, rdat, waits);
    check("rx_read_after_glitch", rdat, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/avm_uart_responder.md
Name: avm_uart_responder

Overview:
- Avalon-MM slave that is the responder end of the host-side serial link: it answers the RX/TX/STATUS register protocol that our Avalon master wrappers poll, and moves bytes over a UART pin pair (8N1).
- Sits between the glove-data pipeline's Avalon master and the board RS-232 pins.
- Lets bring-up run without the vendor UART IP, and lets the bench loop our master FSMs back against a known responder.

Parameters:
- CLK_FREQ, 50_000_000, avm_clk frequency in Hz.
- BAUD, 115_200, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division), clock cycles per serial bit. Must be at least 4.

Ports:
- avm_clk  in  1  system clock; all logic on its rising edge.
- avm_rst  in  1  reset, asynchronous, active-high.
- avm_address  in  5  byte address: 0 = RX, 4 = TX, 8 = STATUS; other values are reserved.
- avm_read  in  1  read request.
- avm_readdata  out  32  read data; valid only in the cycle where the read completes.
- avm_write  in  1  write request.
- avm_writedata  in  32  write data; only bits [7:0] are used.
- avm_waitrequest  out  1  stall; the transfer completes in the cycle it is low.
- i_uart_rx  in  1  serial input, idles high, asynchronous to avm_clk.
- o_uart_tx  out  1  serial output, idles high.

Behaviour:
- Reset values:
  - avm_waitrequest = 1, avm_readdata = 0, o_uart_tx = 1.
  - rx_valid = 0, tx_busy = 0, overrun = 0.
  - RX and TX FSMs in IDLE.
- Bus handshake:
  - Every access has a fixed latency of 1 wait cycle: waitrequest stays 1 in the cycle read or write is first seen, then drops to 0 for exactly one cycle.
  - In that cycle readdata is valid and any side effects commit.
  - waitrequest then returns to 1.
  - The master must hold address, read, write and writedata until waitrequest is low.
  - read and write asserted together: the read wins and the write is ignored.
- Register map:
  - RX (0): readdata = {24'b0, rx_byte}. A completed RX read clears rx_valid.
  - TX (4): a write with tx_busy = 0 loads writedata[7:0] and starts TX. A write with tx_busy = 1 is silently dropped; the bus still completes normally.
  - STATUS (8): readdata[6] = TX_OK = !tx_busy; readdata[7] = RX_OK = rx_valid; readdata[0] = overrun; all other bits 0. A completed STATUS read clears overrun.
  - Reserved addresses: reads return 0, writes have no effect, and the bus completes normally.
- RX path:
  - 2-flop synchronizer on i_uart_rx.
  - FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a falling edge.
  - START samples at CLKS_PER_BIT/2. If the line is still low, go to DATA; if high, treat it as a glitch and return to IDLE.
  - DATA samples 8 bits, LSB first, one every CLKS_PER_BIT.
  - STOP samples once. If the stop bit is 1, rx_byte is loaded and rx_valid is set. If the stop bit is 0 (framing error), the byte is discarded and the FSM returns to IDLE.
  - A new byte arriving while rx_valid = 1 overwrites rx_byte and sets overrun.
  - A byte that completes in the same cycle as an RX read: the byte is kept (rx_valid stays 1) and overrun is not set.
- TX path:
  - FSM states: IDLE, START, DATA, STOP.
  - The line is driven low for 1 bit time, then 8 data bits LSB first, then high for 1 stop bit.
  - The whole frame is 10 bit times; tx_busy is 1 for exactly 10*CLKS_PER_BIT cycles.
  - The first start-bit cycle is the cycle after the write completes.
- Counters: bit counter 3 bits; baud counter $clog2(CLKS_PER_BIT) bits; both wrap cleanly with no off-by-one at the bit boundaries.
- Reset asserted mid-frame: both FSMs abort immediately, o_uart_tx goes to 1 asynchronously, and any partially received byte is discarded.

Optional Feature:
- Macro: AVM_UART_RX_FIFO_EN.
- When defined:
  - An 8-entry RX FIFO replaces the single rx_byte register.
  - RX_OK means "FIFO not empty"; an RX read pops the FIFO.
  - A byte arriving with the FIFO full is dropped and sets overrun.
  - A push and a pop in the same cycle with the FIFO full are both honoured.
- When undefined: single-byte holding register with the overwrite semantics above.

Decomposition:
- Package uart_pkg holds:
  - RX_BASE = 0, TX_BASE = 4, STATUS_BASE = 8.
  - TX_OK_BIT = 6, RX_OK_BIT = 7, OVR_BIT = 0.
  - The typedef enum for the 2-bit uart_state_t (IDLE, START, DATA, STOP), shared by both FSMs.
- Sub-module uart_rx_core: synchronizer, RX FSM and byte output with a valid pulse, instantiated once.
- The TX FSM and Avalon decode stay in the top module.

Test Plan:
All scenarios use CLK_FREQ = 1_000_000 and BAUD = 100_000, so CLKS_PER_BIT = 10.
- Reset then STATUS read -> waitrequest is 1 for 1 cycle, then readdata = 0x0000_0040 (TX_OK only); o_uart_tx = 1.
- Write 0xA5 to TX -> o_uart_tx carries 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles; STATUS reads 0x00 mid-frame and 0x40 after 100 cycles.
- Second TX write of 0x3C at cycle 20 of a frame -> dropped; only the 0xA5 frame appears on the line.
- Drive frame 0x5A on i_uart_rx -> STATUS = 0xC0; RX read returns 0x0000_005A; STATUS then reads 0x40.
- Two frames (0x11 then 0x22) with no RX read between them -> STATUS = 0xC1; RX read returns 0x22; next STATUS read = 0x40 (overrun cleared). With AVM_UART_RX_FIFO_EN: RX reads return 0x11 then 0x22, and overrun stays 0.
- avm_rst pulsed at TX bit 4 -> o_uart_tx = 1 in the same cycle; STATUS = 0x40 after reset; a 3-cycle low glitch on i_uart_rx produces no byte.
